// File: rtl/vending_stimulus_seq.sv
// Purchase-sequence generator for the vending-machine controller: queued
// transactions play out as ESCOLHER -> INSERIR -> TROCO -> LIMPAR.
module vending_stimulus_seq #(
  parameter int PROD_W       = 8,
  parameter int COIN_W       = 8,
  parameter int MONEY_W      = 8,
  parameter int DEPTH        = 4,
  parameter int PHASE_CYCLES = 1,
  parameter int TROCO_CYCLES = 3,
  parameter int GAP_CYCLES   = 1,
  parameter int DENOM_A      = 25,
  parameter int DENOM_B      = 50,
  parameter int DENOM_C      = 100,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PROD_W-1:0]  cmd_produto,
  input  logic [COIN_W-1:0]  cmd_moedas_25,
  input  logic [COIN_W-1:0]  cmd_moedas_50,
  input  logic [COIN_W-1:0]  cmd_moedas_100,
  output logic [1:0]         escolher,
  output logic [1:0]         inserir_dinheiro,
  output logic [1:0]         dar_troco,
  output logic [7:0]         produto_escolhido,
  output logic [MONEY_W-1:0] dinheiro_inserido,
  output logic [COIN_W-1:0]  moedas_inseridas_25,
  output logic [COIN_W-1:0]  moedas_inseridas_50,
  output logic [COIN_W-1:0]  moedas_inseridas_100,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   transacoes,
  output logic               erro_saturacao
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = MONEY_W + COIN_W + 8;
  localparam int PC_W  = 16;

  typedef enum logic [2:0] {IDLE, ESCOLHER, INSERIR, TROCO, LIMPAR} state_t;

  state_t            state;
  logic [PC_W-1:0]   phase_cnt;
  logic              phase_last;

  logic [PROD_W-1:0] q_prod [DEPTH];
  logic [COIN_W-1:0] q_a    [DEPTH];
  logic [COIN_W-1:0] q_b    [DEPTH];
  logic [COIN_W-1:0] q_c    [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;

  logic [PROD_W-1:0] cur_prod;
  logic [COIN_W-1:0] cur_a, cur_b, cur_c;
  logic [SUM_W-1:0]  sum_full;
  logic [MONEY_W-1:0] sum_sat;
  logic              sum_ovf;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    phase_last = 1'b0;
    unique case (state)
      ESCOLHER, INSERIR: phase_last = (phase_cnt == PC_W'(PHASE_CYCLES - 1));
      TROCO:             phase_last = (phase_cnt == PC_W'(TROCO_CYCLES - 1));
      LIMPAR:            phase_last = (phase_cnt == PC_W'(GAP_CYCLES - 1));
      default:           phase_last = 1'b0;
    endcase
  end

  assign pop = !empty && ((state == IDLE) || ((state == LIMPAR) && phase_last));

  // Full-width sum so that overflow can be detected before saturating.
  assign sum_full = SUM_W'(cur_a) * SUM_W'(DENOM_A)
                  + SUM_W'(cur_b) * SUM_W'(DENOM_B)
                  + SUM_W'(cur_c) * SUM_W'(DENOM_C);
  assign sum_ovf  = (sum_full > SUM_W'({MONEY_W{1'b1}}));
  assign sum_sat  = sum_ovf ? '1 : sum_full[MONEY_W-1:0];

  // NOTE: queue storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_prod[wr_ptr] <= cmd_produto;
      q_a[wr_ptr]    <= cmd_moedas_25;
      q_b[wr_ptr]    <= cmd_moedas_50;
      q_c[wr_ptr]    <= cmd_moedas_100;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      phase_cnt            <= '0;
      cur_prod             <= '0;
      cur_a                <= '0;
      cur_b                <= '0;
      cur_c                <= '0;
      escolher             <= '0;
      inserir_dinheiro     <= '0;
      dar_troco            <= '0;
      produto_escolhido    <= '0;
      dinheiro_inserido    <= '0;
      moedas_inseridas_25  <= '0;
      moedas_inseridas_50  <= '0;
      moedas_inseridas_100 <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      transacoes           <= '0;
      erro_saturacao       <= 1'b0;
    end else begin
      // Outputs decode the present state, so they trail it by exactly one cycle.
      escolher          <= {1'b0, state == ESCOLHER};
      inserir_dinheiro  <= {1'b0, state == INSERIR};
      dar_troco         <= {1'b0, state == TROCO};
      done              <= (state == TROCO) && phase_last;
      busy              <= (state != IDLE) || !empty;
      produto_escolhido <= (state inside {ESCOLHER, INSERIR, TROCO}) ? 8'(cur_prod) : 8'd0;
      if (state inside {INSERIR, TROCO}) begin
        dinheiro_inserido    <= sum_sat;
        moedas_inseridas_25  <= cur_a;
        moedas_inseridas_50  <= cur_b;
        moedas_inseridas_100 <= cur_c;
      end else begin
        dinheiro_inserido    <= '0;
        moedas_inseridas_25  <= '0;
        moedas_inseridas_50  <= '0;
        moedas_inseridas_100 <= '0;
      end
      if ((state == INSERIR) && sum_ovf) erro_saturacao <= 1'b1;
      if ((state == TROCO) && phase_last) transacoes <= transacoes + 1'b1;

      phase_cnt <= phase_cnt + 1'b1;
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (pop) begin
            state    <= ESCOLHER;
            cur_prod <= q_prod[rd_ptr];
            cur_a    <= q_a[rd_ptr];
            cur_b    <= q_b[rd_ptr];
            cur_c    <= q_c[rd_ptr];
          end
        end
        ESCOLHER: if (phase_last) begin state <= INSERIR; phase_cnt <= '0; end
        INSERIR:  if (phase_last) begin state <= TROCO;   phase_cnt <= '0; end
        TROCO:    if (phase_last) begin state <= LIMPAR;  phase_cnt <= '0; end
        LIMPAR: begin
          if (phase_last) begin
            phase_cnt <= '0;
            if (pop) begin
              state    <= ESCOLHER;
              cur_prod <= q_prod[rd_ptr];
              cur_a    <= q_a[rd_ptr];
              cur_b    <= q_b[rd_ptr];
              cur_c    <= q_c[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_stimulus_seq.sv
// Directed bench for vending_stimulus_seq: queued expectations are compared
// phase by phase as each transaction plays out.
module tb_vending_stimulus_seq;

  localparam int CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_produto = '0;
  logic [7:0]       cmd_moedas_25 = '0;
  logic [7:0]       cmd_moedas_50 = '0;
  logic [7:0]       cmd_moedas_100 = '0;
  logic [1:0]       escolher, inserir_dinheiro, dar_troco;
  logic [7:0]       produto_escolhido, dinheiro_inserido;
  logic [7:0]       moedas_inseridas_25, moedas_inseridas_50, moedas_inseridas_100;
  logic             busy, done, erro_saturacao;
  logic [CNT_W-1:0] transacoes;

  typedef struct {
    logic [7:0] prod;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] money;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   txn_exp = 0;
  logic err_exp = 1'b0;

  vending_stimulus_seq #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_produto(cmd_produto), .cmd_moedas_25(cmd_moedas_25),
    .cmd_moedas_50(cmd_moedas_50), .cmd_moedas_100(cmd_moedas_100),
    .escolher(escolher), .inserir_dinheiro(inserir_dinheiro), .dar_troco(dar_troco),
    .produto_escolhido(produto_escolhido), .dinheiro_inserido(dinheiro_inserido),
    .moedas_inseridas_25(moedas_inseridas_25), .moedas_inseridas_50(moedas_inseridas_50),
    .moedas_inseridas_100(moedas_inseridas_100),
    .busy(busy), .done(done), .transacoes(transacoes), .erro_saturacao(erro_saturacao)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "escolher"}, escolher, 0);
    check({pfx, "inserir"}, inserir_dinheiro, 0);
    check({pfx, "troco"}, dar_troco, 0);
    check({pfx, "produto"}, produto_escolhido, 0);
    check({pfx, "dinheiro"}, dinheiro_inserido, 0);
    check({pfx, "m25"}, moedas_inseridas_25, 0);
    check({pfx, "m50"}, moedas_inseridas_50, 0);
    check({pfx, "m100"}, moedas_inseridas_100, 0);
    check({pfx, "busy"}, busy, 0);
    check({pfx, "done"}, done, 0);
    check({pfx, "transacoes"}, transacoes, 0);
    check({pfx, "erro"}, erro_saturacao, 0);
    check({pfx, "ready"}, cmd_ready, 1);
  endtask

  // Offer one command for one cycle; record the expectation if it should be accepted.
  task automatic present(input int p, input int a, input int b, input int c, input bit exp_ready);
    exp_t e;
    int   s;
    cmd_valid      = 1'b1;
    cmd_produto    = 8'(p);
    cmd_moedas_25  = 8'(a);
    cmd_moedas_50  = 8'(b);
    cmd_moedas_100 = 8'(c);
    check("cmd_ready", cmd_ready, exp_ready);
    if (exp_ready) begin
      s       = a * 25 + b * 50 + c * 100;
      e.prod  = 8'(p);
      e.a     = 8'(a);
      e.b     = 8'(b);
      e.c     = 8'(c);
      e.sat   = (s > 255);
      e.money = e.sat ? 8'hFF : 8'(s);
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic wait_esc(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      n++;
      if (escolher == 2'd1) break;
    end
  endtask

  // Entered on the negedge where escolher is first seen high.
  task automatic check_txn();
    exp_t e;
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("esc_strobe", escolher, 1);
    check("esc_produto", produto_escolhido, e.prod);
    check("esc_dinheiro", dinheiro_inserido, 0);
    check("esc_m25", moedas_inseridas_25, 0);
    check("esc_m100", moedas_inseridas_100, 0);
    @(negedge clock);
    err_exp = err_exp | e.sat;
    check("ins_strobe", inserir_dinheiro, 1);
    check("ins_esc_off", escolher, 0);
    check("ins_produto", produto_escolhido, e.prod);
    check("ins_dinheiro", dinheiro_inserido, e.money);
    check("ins_m25", moedas_inseridas_25, e.a);
    check("ins_m50", moedas_inseridas_50, e.b);
    check("ins_m100", moedas_inseridas_100, e.c);
    check("ins_erro", erro_saturacao, err_exp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("troco_strobe", dar_troco, 1);
      check("troco_ins_off", inserir_dinheiro, 0);
      check("troco_dinheiro", dinheiro_inserido, e.money);
      check("troco_done", done, (i == 2));
      if (i == 2) begin
        txn_exp++;
        check("transacoes", transacoes, 32'(txn_exp % (1 << CNT_W)));
      end
    end
    @(negedge clock);
    check("limpar_strobes", {escolher, inserir_dinheiro, dar_troco}, 0);
    check("limpar_dinheiro", dinheiro_inserido, 0);
    check("limpar_produto", produto_escolhido, 0);
    check("limpar_done", done, 0);
  endtask

  initial begin
    int   n;
    int   seen;
    exp_t drop;

    // Power-on reset, checked asynchronously before any clock edge.
    #1 reset = 1'b1;
    #2 check_idle("rst_");
    @(negedge clock) reset = 1'b0;
    check("rst_release_ready", cmd_ready, 1);

    // Single transaction from IDLE: latency, phases, return to IDLE.
    present(1, 0, 1, 1, 1);
    cmd_valid = 1'b0;
    wait_esc(n);
    check("latency", n, 2);
    check_txn();
    @(negedge clock);
    check("idle_busy", busy, 0);

    // Back-to-back pair: one all-zero cycle between them.
    present(1, 0, 1, 1, 1);
    present(2, 2, 1, 0, 1);
    cmd_valid = 1'b0;
    wait_esc(n);
    check_txn();
    wait_esc(n);
    check("b2b_gap", n, 1);
    check_txn();

    // Saturating total, then a normal one: the error flag stays set.
    @(negedge clock);
    present(3, 0, 0, 3, 1);
    present(4, 1, 0, 0, 1);
    cmd_valid = 1'b0;
    wait_esc(n);
    check_txn();
    wait_esc(n);
    check("sat_gap", n, 1);
    check_txn();
    @(negedge clock);
    check("wrap_after_5", transacoes, 1);
    check("erro_sticky", erro_saturacao, 1);
    check("sat_idle_busy", busy, 0);

    // Fill the queue while the first command plays: only four are taken.
    present(5, 1, 1, 1, 1);
    present(10, 1, 0, 0, 1);
    present(11, 0, 1, 0, 1);
    present(12, 0, 0, 1, 1);
    present(13, 2, 0, 0, 1);
    present(14, 0, 2, 0, 0);
    present(15, 0, 0, 2, 0);
    cmd_valid = 1'b0;
    check("full_ready", cmd_ready, 0);
    drop = sb.pop_front();
    txn_exp++;
    wait_esc(n);
    check_txn();
    for (int i = 0; i < 3; i++) begin
      wait_esc(n);
      check("fill_gap", n, 1);
      check_txn();
    end
    @(negedge clock);
    check("fill_idle_busy", busy, 0);

    // Reset in the middle of TROCO with a second command still queued.
    present(6, 1, 1, 0, 1);
    present(7, 0, 0, 1, 1);
    cmd_valid = 1'b0;
    wait_esc(n);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_troco", dar_troco, 1);
    #2 reset = 1'b1;
    #1 check_idle("mrst_");
    sb.delete();
    txn_exp = 0;
    err_exp = 1'b0;
    @(negedge clock) reset = 1'b0;
    check("mrst_release_ready", cmd_ready, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (escolher != 2'd0) seen++;
    end
    check("mrst_queue_empty", seen, 0);
    check("mrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_stimulus_seq.md
Name: vending_stimulus_seq

Overview:
- Synthesizable, parametrised purchase-sequence generator that drives the vending-machine controller inputs.
- Replaces hard-coded timed stimulus with a command queue: each queued transaction (product plus coin counts) plays out as the phase sequence choose -> insert money -> give change -> clear.
- Computes the inserted-money total from coin counts and denominations.
- Reports completions, saturation errors and busy status to the bench or host.

Parameters:
- PROD_W, 8, width of product code
- COIN_W, 8, width of each coin-count field
- MONEY_W, 8, width of dinheiro_inserido
- DEPTH, 4, transaction queue depth (power of 2, >=2)
- PHASE_CYCLES, 1, cycles spent in each of ESCOLHER and INSERIR (>=1)
- TROCO_CYCLES, 3, cycles spent in TROCO (>=1)
- GAP_CYCLES, 1, cycles spent in LIMPAR between transactions (>=1)
- DENOM_A, 25, value of coin type A
- DENOM_B, 50, value of coin type B
- DENOM_C, 100, value of coin type C
- CNT_W, 8, width of completed-transaction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  transaction offered
- cmd_ready  out  1  queue can accept; equals !full
- cmd_produto  in  PROD_W  product code
- cmd_moedas_25  in  COIN_W  count of coin A
- cmd_moedas_50  in  COIN_W  count of coin B
- cmd_moedas_100  in  COIN_W  count of coin C
- escolher  out  2  1 during ESCOLHER, else 0
- inserir_dinheiro  out  2  1 during INSERIR, else 0
- dar_troco  out  2  1 during TROCO, else 0
- produto_escolhido  out  8  product to controller (PROD_W zero-extended or truncated to 8)
- dinheiro_inserido  out  MONEY_W  total inserted value
- moedas_inseridas_25  out  COIN_W  coin A count to controller
- moedas_inseridas_50  out  COIN_W  coin B count to controller
- moedas_inseridas_100  out  COIN_W  coin C count to controller
- busy  out  1  state != IDLE or queue non-empty
- done  out  1  one-cycle pulse on exit from TROCO
- transacoes  out  CNT_W  completed transactions; wraps modulo 2^CNT_W
- erro_saturacao  out  1  sticky; a total exceeded the MONEY_W range

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any state including mid-transaction):
  - state IDLE, queue emptied.
  - All data and strobe outputs, done, transacoes and erro_saturacao = 0.
  - busy = 0; cmd_ready = 1 while reset is held.
- Push: on an edge with cmd_valid && cmd_ready.
  - No bypass: an entry becomes visible to the FSM on the next cycle.
  - Push and pop in the same cycle are allowed when not full.
- States (all outputs registered, Moore):
  - IDLE: all outputs 0. Queue non-empty -> pop, go ESCOLHER.
  - ESCOLHER (PHASE_CYCLES): escolher=1, produto_escolhido=entry product, dinheiro=0, moedas=0. On timeout -> INSERIR.
  - INSERIR (PHASE_CYCLES): inserir_dinheiro=1, produto held, moedas = entry counts, dinheiro_inserido = sum. On timeout -> TROCO.
  - TROCO (TROCO_CYCLES): dar_troco=1, all data held. On the last cycle: done pulse, transacoes+1, then -> LIMPAR.
  - LIMPAR (GAP_CYCLES): all outputs 0. On timeout: queue non-empty -> pop, go ESCOLHER; else -> IDLE.
- Latency: a command accepted at edge k into an empty queue while IDLE gives escolher=1 after edge k+2.
- Only one strobe is ever non-zero. Bit 1 of each strobe is always 0.
- Sum: A*DENOM_A + B*DENOM_B + C*DENOM_C, computed at full width (MONEY_W + COIN_W + 8 bits).
  - If the sum exceeds 2^MONEY_W-1: output saturates to 2^MONEY_W-1 and erro_saturacao is set.
  - erro_saturacao stays set until reset; the sequence continues normally.
- Full queue: cmd_ready=0 and cmd_valid is ignored (no overwrite). Queue order is FIFO.
- Phase counters reload on every state entry.

Test Plan:
- Reset mid-TROCO -> all outputs 0 in the same cycle (async); queue empty; transacoes=0; cmd_ready=1 after release.
- Push {prod=1, 0,1,1} while IDLE:
  - escolher=1 with produto=1, dinheiro=0 for 1 cycle.
  - inserir=1 with dinheiro=150, moedas 0/1/1 for 1 cycle.
  - dar_troco=1 for 3 cycles; done on the 3rd; transacoes=1.
  - LIMPAR for 1 cycle, then IDLE with busy=0.
- Back-to-back {1,0,1,1} then {2,2,1,0} -> second transaction shows dinheiro=100, moedas 2/1/0. Exactly 1 all-zero cycle between the two TROCO and ESCOLHER phases; transacoes=2.
- Hold cmd_valid with 6 distinct commands while busy -> exactly DEPTH=4 accepted, cmd_ready=0 thereafter, playback in push order.
- Push {prod=3, 0,0,3} -> dinheiro_inserido=255, erro_saturacao=1 and still 1 after a following valid transaction.
- CNT_W=2 with 5 transactions -> transacoes reads 1 (wrap). done pulses exactly 5 times, each 1 cycle wide.
